uart_mem_bridge: RTL and testbench
==================================

Name: uart_mem_bridge

Overview:
Byte-protocol bridge between a byte-wide UART core (rx_data/rx_ready in; tx_buff/tx_start_trans/tx_ready out) and a synchronous single-port memory.
- Generalises the single-byte read/write interface: parametrised address and data widths, burst transfers of 1..256 words, and configurable memory read latency.
- Adds a write acknowledge, a NAK for unknown commands, and an inter-byte timeout that aborts stalled frames.

Parameters:
ADDR_WIDTH, 16, memory address width in bits; multiple of 8, range 8..32; ADDR_BYTES = ADDR_WIDTH/8
DATA_WIDTH, 8, memory word width in bits; multiple of 8, range 8..32; DATA_BYTES = DATA_WIDTH/8
READ_CMD, 8'h00, command byte for a burst read
WRITE_CMD, 8'hFF, command byte for a burst write
ACK_BYTE, 8'hA5, byte returned after a completed write burst
NAK_BYTE, 8'h5A, byte returned for an unknown command
RD_LATENCY, 1, cycles from rd assertion to din valid (1..4)
TIMEOUT_CYCLES, 1000000, max idle cycles between received bytes inside a frame

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte, valid when rx_ready=1
rx_ready  in  1  one-cycle pulse per received byte
tx_ready  in  1  UART transmitter idle
tx_buff  out  8  byte to transmit
tx_start_trans  out  1  one-cycle transmit start pulse
addr  out  ADDR_WIDTH  memory address
dout  out  DATA_WIDTH  memory write data
din  in  DATA_WIDTH  memory read data
wr  out  1  one-cycle write strobe
rd  out  1  one-cycle read strobe
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0, including tx_buff, addr, dout, wr, rd, tx_start_trans and busy; all counters 0.
- Frame format: CMD, then ADDR_BYTES address bytes (MSB first), then LEN byte (burst = LEN+1 words).
  - Write frame: followed by (LEN+1)*DATA_BYTES data bytes, each word MSB first.
  - Read frame: the block replies with (LEN+1)*DATA_BYTES bytes, each word MSB first.
- States: IDLE, GET_ADDR, GET_LEN, GET_DATA, MEM_WR, MEM_RD, RD_WAIT, TX_SEND, TX_WAIT.
- IDLE, on rx_ready:
  - rx_data==READ_CMD or WRITE_CMD: latch the command, go to GET_ADDR.
  - Any other byte: load NAK_BYTE and go to TX_SEND; return to IDLE after it is sent.
- GET_ADDR: shift in ADDR_BYTES bytes, then go to GET_LEN.
- GET_LEN: latch LEN; write command -> GET_DATA, read command -> MEM_RD.
- GET_DATA / MEM_WR (write path):
  - Assemble DATA_BYTES bytes into dout, then MEM_WR.
  - MEM_WR: wr=1 for exactly one cycle with addr/dout stable that cycle.
  - Then addr += 1 (wraps modulo 2^ADDR_WIDTH) and word count += 1.
  - More words remaining -> GET_DATA; last word -> load ACK_BYTE and go to TX_SEND.
- MEM_RD / RD_WAIT / TX_SEND (read path):
  - MEM_RD: rd=1 for one cycle.
  - RD_WAIT: wait RD_LATENCY cycles, capture din into a shift register, go to TX_SEND.
  - Each transmitted byte shifts out the next byte of the word.
  - After the last byte of a word: addr += 1 (wrap); if words remain -> MEM_RD, else IDLE.
- TX_SEND / TX_WAIT (transmit handshake):
  - TX_SEND waits for tx_ready=1, then pulses tx_start_trans for one cycle; tx_buff is held stable from that cycle until the next pulse.
  - TX_WAIT ignores tx_ready for 1 cycle, then waits for tx_ready=1 before the next byte.
- rx_ready pulses during MEM_RD, RD_WAIT, TX_SEND and TX_WAIT are discarded, with no state effect.
- Timeout:
  - In GET_ADDR, GET_LEN and GET_DATA, a counter clears on each rx_ready and increments otherwise.
  - Reaching TIMEOUT_CYCLES returns the block to IDLE with no memory write for the partial word and no ACK.
  - Words already written in the burst remain written.
- LEN=255 gives 256 words; the word counter is 9 bits wide, or wide enough to hold 256.
- rst_n asserted mid-frame aborts immediately, including an in-flight wr/rd strobe; tx_start_trans deasserts asynchronously.
- Throughput: one memory access per word; no pipelining across words.

Test Plan:
- Default params, send FF 00 10 00 3C -> one wr pulse with addr=16'h0010, dout=8'h3C; then tx_buff=8'hA5 with one tx_start_trans pulse.
- Memory model holding 8'h11,8'h22,8'h33 at 0x0010..0x0012; send 00 00 10 02 -> rd pulses at 0x0010,0x0011,0x0012; transmitted bytes 11 22 33, each start pulse only while tx_ready=1.
- DATA_WIDTH=16, ADDR_WIDTH=8; send FF FF 01 12 34 56 78 -> wr at addr 8'hFF, dout 16'h1234; then wr at addr 8'h00 (wrap), dout 16'h5678; then ACK.
- Send byte 8'h42 in IDLE -> single tx of 8'h5A, wr/rd never asserted, busy returns to 0.
- TIMEOUT_CYCLES=100; send FF 00 20 00 then stall 101 cycles -> busy falls, no wr, no tx. A following valid write frame completes normally.
- Deassert rst_n during the TX_WAIT of a 4-word read -> all outputs 0 immediately. After release, busy=0 and a new read frame works.

Source files
------------

// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge
// Byte-protocol bridge between a byte-wide UART core and a synchronous
// single-port memory. A frame is CMD, ADDR_BYTES address bytes (MSB first)
// and a LEN byte. The burst is LEN+1 words. A write frame carries the data
// words, each MSB first, and is acknowledged with ACK_BYTE. A read frame is
// answered with the data words, each MSB first. An unknown command byte is
// answered with NAK_BYTE. If the gap between received bytes inside a frame
// reaches TIMEOUT_CYCLES, the frame is dropped.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   rx_data         received byte, valid while rx_ready is high
//   rx_ready        one-cycle pulse per received byte
//   tx_ready        UART transmitter idle
//   tx_buff         byte to transmit, held from the start pulse to the next one
//   tx_start_trans  one-cycle transmit start pulse, only while tx_ready is high
//   addr            memory address
//   dout            memory write data
//   din             memory read data, valid RD_LATENCY cycles after rd
//   wr, rd          one-cycle memory write and read strobes
//   busy            high whenever the bridge is not idle
module uart_mem_bridge #(
    parameter int         ADDR_WIDTH     = 16,
    parameter int         DATA_WIDTH     = 8,
    parameter logic [7:0] READ_CMD       = 8'h00,
    parameter logic [7:0] WRITE_CMD      = 8'hFF,
    parameter logic [7:0] ACK_BYTE       = 8'hA5,
    parameter logic [7:0] NAK_BYTE       = 8'h5A,
    parameter int         RD_LATENCY     = 1,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_ready,
    input  logic                  tx_ready,
    output logic [7:0]            tx_buff,
    output logic                  tx_start_trans,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  wr,
    output logic                  rd,
    output logic                  busy
);

    localparam int ADDR_BYTES = ADDR_WIDTH / 8;
    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int TO_W       = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, GET_ADDR, GET_LEN, GET_DATA, MEM_WR, MEM_RD, RD_WAIT, TX_SEND, TX_WAIT
    } state_t;

    state_t state, next_state;

    logic                  is_write;  // latched command of the current frame
    logic                  tx_resp;   // byte in tx_buff is ACK/NAK, not read data
    logic                  tx_hold;   // first TX_WAIT cycle, tx_ready not yet meaningful
    logic [7:0]            len;
    logic [8:0]            word_cnt;  // must reach 256 for LEN=255
    logic [2:0]            byte_cnt;  // byte index within address, data word or tx word
    logic [2:0]            lat_cnt;
    logic [TO_W-1:0]       tout_cnt;
    logic [DATA_WIDTH-1:0] rd_shift;  // remaining bytes of the word being transmitted

    logic in_frame, tout_hit, addr_last, data_last, word_last, lat_done, tx_done;

    // NOTE: every signal driven from always_comb gets a default at the top, so
    // no path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        in_frame  = (state == GET_ADDR) || (state == GET_LEN) || (state == GET_DATA);
        tout_hit  = in_frame && !rx_ready && (tout_cnt == TO_W'(TIMEOUT_CYCLES - 1));
        addr_last = (byte_cnt == 3'(ADDR_BYTES - 1));
        data_last = (byte_cnt == 3'(DATA_BYTES - 1));
        word_last = (word_cnt == {1'b0, len});
        lat_done  = (lat_cnt == 3'(RD_LATENCY - 1));
        tx_done   = !tx_hold && tx_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Strobes are decoded from the state register, so they are exactly one
    // cycle wide and drop the instant reset clears the state.
    always_comb begin
        next_state     = state;
        wr             = 1'b0;
        rd             = 1'b0;
        tx_start_trans = 1'b0;
        busy           = (state != IDLE);
        case (state)
            IDLE: begin
                if (rx_ready) begin
                    if (rx_data == READ_CMD || rx_data == WRITE_CMD) next_state = GET_ADDR;
                    else                                             next_state = TX_SEND;
                end
            end
            GET_ADDR: begin
                if (tout_hit)                    next_state = IDLE;
                else if (rx_ready && addr_last)  next_state = GET_LEN;
            end
            GET_LEN: begin
                if (tout_hit)      next_state = IDLE;
                else if (rx_ready) next_state = is_write ? GET_DATA : MEM_RD;
            end
            GET_DATA: begin
                if (tout_hit)                    next_state = IDLE;
                else if (rx_ready && data_last)  next_state = MEM_WR;
            end
            MEM_WR: begin
                wr         = 1'b1;
                next_state = word_last ? TX_SEND : GET_DATA;
            end
            MEM_RD: begin
                rd         = 1'b1;
                next_state = RD_WAIT;
            end
            RD_WAIT: begin
                if (lat_done) next_state = TX_SEND;
            end
            TX_SEND: begin
                if (tx_ready) begin
                    tx_start_trans = 1'b1;
                    next_state     = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (tx_done) begin
                    if (tx_resp)         next_state = IDLE;
                    else if (!data_last) next_state = TX_SEND;
                    else if (word_last)  next_state = IDLE;
                    else                 next_state = MEM_RD;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_write <= 1'b0;
            tx_resp  <= 1'b0;
            tx_hold  <= 1'b0;
            len      <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            lat_cnt  <= '0;
            tout_cnt <= '0;
            rd_shift <= '0;
            tx_buff  <= '0;
            addr     <= '0;
            dout     <= '0;
        end else begin
            // Idle-gap counter runs only while a frame is being received.
            if (!in_frame || rx_ready) tout_cnt <= '0;
            else                       tout_cnt <= tout_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (rx_ready) begin
                        byte_cnt <= '0;
                        word_cnt <= '0;
                        is_write <= (rx_data == WRITE_CMD);
                        if (rx_data != READ_CMD && rx_data != WRITE_CMD) begin
                            tx_buff <= NAK_BYTE;
                            tx_resp <= 1'b1;
                        end
                    end
                end
                GET_ADDR: begin
                    if (rx_ready) begin
                        addr     <= (addr << 8) | ADDR_WIDTH'(rx_data);
                        byte_cnt <= addr_last ? 3'd0 : byte_cnt + 1'b1;
                    end
                end
                GET_LEN: begin
                    if (rx_ready) len <= rx_data;
                end
                GET_DATA: begin
                    if (rx_ready) begin
                        dout     <= (dout << 8) | DATA_WIDTH'(rx_data);
                        byte_cnt <= data_last ? 3'd0 : byte_cnt + 1'b1;
                    end
                end
                MEM_WR: begin
                    addr     <= addr + 1'b1;
                    word_cnt <= word_cnt + 1'b1;
                    if (word_last) begin
                        tx_buff <= ACK_BYTE;
                        tx_resp <= 1'b1;
                    end
                end
                MEM_RD: begin
                    lat_cnt <= '0;
                end
                RD_WAIT: begin
                    if (lat_done) begin
                        tx_buff  <= din[DATA_WIDTH-1 -: 8];
                        rd_shift <= din << 8;
                        byte_cnt <= '0;
                        tx_resp  <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                TX_SEND: begin
                    if (tx_ready) tx_hold <= 1'b1;
                end
                TX_WAIT: begin
                    tx_hold <= 1'b0;
                    if (tx_done && !tx_resp) begin
                        if (!data_last) begin
                            tx_buff  <= rd_shift[DATA_WIDTH-1 -: 8];
                            rd_shift <= rd_shift << 8;
                            byte_cnt <= byte_cnt + 1'b1;
                        end else begin
                            addr     <= addr + 1'b1;
                            word_cnt <= word_cnt + 1'b1;
                            byte_cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Bench for uart_mem_bridge with 16-bit address, 16-bit words, read latency 2
// and a 100-cycle inter-byte timeout. Frames are driven byte by byte. The
// expected memory writes, read addresses and transmitted bytes are queued when
// a frame is issued, and a negedge monitor pops them as the DUT strobes wr, rd
// and tx_start_trans. A UART model drops tx_ready after each start pulse and
// at random moments. A memory model with a two-stage read pipeline drives din.
module tb_uart_mem_bridge;

    localparam int LAT = 2;
    localparam int TO  = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_ready;
    logic [7:0]  tx_buff;
    logic        tx_start_trans;
    logic [15:0] addr, dout, din;
    logic        wr, rd, busy;

    uart_mem_bridge #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16), .RD_LATENCY(LAT), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_ready(tx_ready), .tx_buff(tx_buff), .tx_start_trans(tx_start_trans),
        .addr(addr), .dout(dout), .din(din), .wr(wr), .rd(rd), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic [15:0] a; logic [15:0] d; } wr_t;
    wr_t         exp_wr_q[$];
    logic [15:0] exp_rd_q[$];
    logic [7:0]  exp_tx_q[$];
    logic [15:0] ref_mem [logic [15:0]];

    function automatic logic [15:0] init_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // ---------------- memory model ----------------
    logic [15:0] mem [65536];
    logic        mem_init_done = 1'b0;
    logic [15:0] pipe_d [LAT];
    logic [LAT-1:0] pipe_v;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 65536; i++) mem[i] <= init_word(16'(i));
            mem_init_done <= 1'b1;
        end else if (wr && rst_n) begin
            mem[addr] <= dout;
        end
        if (!rst_n) begin
            pipe_v <= '0;
        end else begin
            pipe_v    <= {pipe_v[LAT-2:0], rd};
            pipe_d[0] <= mem[addr];
            pipe_d[1] <= pipe_d[0];
        end
    end

    assign din = pipe_v[LAT-1] ? pipe_d[LAT-1] : 16'hDEAD;

    // ---------------- UART transmitter model ----------------
    logic [7:0] uart_byte;
    int         uart_cnt;
    logic       uart_own;

    always @(posedge clk) begin
        if (!rst_n) begin
            tx_ready <= 1'b1;
            uart_cnt <= 0;
            uart_own <= 1'b0;
        end else if (tx_ready) begin
            if (tx_start_trans) begin
                tx_ready  <= 1'b0;
                uart_byte <= tx_buff;
                uart_own  <= 1'b1;
                uart_cnt  <= int'($urandom_range(1, 5));
            end else if ($urandom_range(0, 15) == 0) begin
                tx_ready <= 1'b0;
                uart_own <= 1'b0;
                uart_cnt <= int'($urandom_range(1, 4));
            end
        end else if (uart_cnt > 1) begin
            uart_cnt <= uart_cnt - 1;
        end else begin
            tx_ready <= 1'b1;
            if (uart_own) check("tx_buff_hold", {24'h0, tx_buff}, {24'h0, uart_byte});
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        wr_t         e;
        logic [15:0] ra;
        logic [7:0]  tb;
        if (rst_n === 1'b1) begin
            if (wr) begin
                check("wr_expected", 32'(exp_wr_q.size() > 0), 32'd1);
                if (exp_wr_q.size() > 0) begin
                    e = exp_wr_q.pop_front();
                    check("wr_addr", {16'h0, addr}, {16'h0, e.a});
                    check("wr_data", {16'h0, dout}, {16'h0, e.d});
                end
            end
            if (rd) begin
                check("rd_expected", 32'(exp_rd_q.size() > 0), 32'd1);
                if (exp_rd_q.size() > 0) begin
                    ra = exp_rd_q.pop_front();
                    check("rd_addr", {16'h0, addr}, {16'h0, ra});
                end
            end
            if (tx_start_trans) begin
                check("tx_start_while_ready", {31'h0, tx_ready}, 32'd1);
                check("tx_expected", 32'(exp_tx_q.size() > 0), 32'd1);
                if (exp_tx_q.size() > 0) begin
                    tb = exp_tx_q.pop_front();
                    check("tx_byte", {24'h0, tx_buff}, {24'h0, tb});
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic send_rnd(input logic [7:0] b);
        send_byte(b, int'($urandom_range(1, 3)));
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i = 0;
        while ((busy || exp_wr_q.size() != 0 || exp_rd_q.size() != 0 || exp_tx_q.size() != 0)
               && i < budget) begin
            @(negedge clk);
            i++;
        end
        check({name, "_completed"}, 32'(i < budget), 32'd1);
    endtask

    task automatic write_frame(input logic [15:0] a, input logic [7:0] len, input logic [15:0] data[$]);
        for (int i = 0; i <= int'(len); i++) begin
            logic [15:0] wa;
            wa = a + 16'(i);
            exp_wr_q.push_back('{a: wa, d: data[i]});
            ref_mem[wa] = data[i];
        end
        exp_tx_q.push_back(8'hA5);
        send_rnd(8'hFF); send_rnd(a[15:8]); send_rnd(a[7:0]); send_rnd(len);
        for (int i = 0; i <= int'(len); i++) begin
            send_rnd(data[i][15:8]);
            send_rnd(data[i][7:0]);
        end
    endtask

    task automatic write_rnd(input logic [15:0] a, input logic [7:0] len);
        logic [15:0] q[$];
        for (int i = 0; i <= int'(len); i++) q.push_back(16'($urandom));
        write_frame(a, len, q);
    endtask

    task automatic read_frame(input logic [15:0] a, input logic [7:0] len);
        for (int i = 0; i <= int'(len); i++) begin
            logic [15:0] ra, w;
            ra = a + 16'(i);
            w  = ref_rd(ra);
            exp_rd_q.push_back(ra);
            exp_tx_q.push_back(w[15:8]);
            exp_tx_q.push_back(w[7:0]);
        end
        send_rnd(8'h00); send_rnd(a[15:8]); send_rnd(a[7:0]); send_rnd(len);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_tx_buff"},        {24'h0, tx_buff},        32'h0);
        check({pfx, "_tx_start_trans"}, {31'h0, tx_start_trans}, 32'h0);
        check({pfx, "_addr"},           {16'h0, addr},           32'h0);
        check({pfx, "_dout"},           {16'h0, dout},           32'h0);
        check({pfx, "_wr"},             {31'h0, wr},             32'h0);
        check({pfx, "_rd"},             {31'h0, rd},             32'h0);
        check({pfx, "_busy"},           {31'h0, busy},           32'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] q[$];
        int          i;
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single-word write, then ACK
        q = {16'h3C5E};
        write_frame(16'h0010, 8'd0, q);
        wait_idle("wr_single", 3000);

        // three-word read covering the word just written; a stray byte during
        // the reply must be ignored (no NAK appears)
        read_frame(16'h0010, 8'd2);
        send_byte(8'h42, 3);
        wait_idle("rd_three", 3000);

        // two-word write across the top of the address space
        q = {16'h1234, 16'h5678};
        write_frame(16'hFFFF, 8'd1, q);
        wait_idle("wr_wrap", 3000);
        read_frame(16'hFFFF, 8'd1);
        wait_idle("rd_wrap", 3000);

        // unknown command -> NAK only
        exp_tx_q.push_back(8'h5A);
        send_rnd(8'h42);
        wait_idle("nak", 3000);

        // timeout after LEN: nothing written, nothing sent
        send_rnd(8'hFF); send_rnd(8'h00); send_rnd(8'h20); send_byte(8'h00, 1);
        repeat (TO - 5) @(negedge clk);
        check("to_busy_before_limit", {31'h0, busy}, 32'd1);
        repeat (10) @(negedge clk);
        check("to_busy_after_limit", {31'h0, busy}, 32'd0);
        write_rnd(16'h0020, 8'd0);
        wait_idle("wr_after_timeout", 3000);

        // timeout mid-burst: first word stays written, partial word dropped, no ACK
        exp_wr_q.push_back('{a: 16'h0030, d: 16'hAABB});
        ref_mem[16'h0030] = 16'hAABB;
        send_rnd(8'hFF); send_rnd(8'h00); send_rnd(8'h30); send_rnd(8'h01);
        send_rnd(8'hAA); send_rnd(8'hBB); send_byte(8'hCC, 1);
        repeat (TO + 10) @(negedge clk);
        check("to_partial_busy", {31'h0, busy}, 32'd0);
        wait_idle("to_partial", 100);
        read_frame(16'h0030, 8'd1);
        wait_idle("rd_after_partial", 3000);

        // maximum bursts (256 words), crossing the address wrap
        write_rnd(16'hFF80, 8'd255);
        wait_idle("wr_max", 20000);
        read_frame(16'hFF80, 8'd255);
        wait_idle("rd_max", 20000);

        // randomised frames
        for (int n = 0; n < 14; n++) begin
            int          kind;
            logic [15:0] a;
            logic [7:0]  len;
            kind = int'($urandom_range(0, 9));
            a    = ($urandom_range(0, 1) == 1) ? 16'(16'hFFF8 + $urandom_range(0, 15))
                                               : 16'(16'h0100 + $urandom_range(0, 31));
            len  = 8'($urandom_range(0, 5));
            if (kind == 0) begin
                exp_tx_q.push_back(8'h5A);
                send_rnd(8'($urandom_range(1, 254)));
            end else if (kind < 5) begin
                write_rnd(a, len);
            end else begin
                read_frame(a, len);
            end
            wait_idle("rnd_frame", 3000);
        end

        // reset during TX_WAIT of a four-word read
        read_frame(16'h0100, 8'd3);
        i = 0;
        while (tx_start_trans !== 1'b1 && i < 500) begin
            @(negedge clk);
            i++;
        end
        check("rst_first_tx_seen", 32'(i < 500), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        exp_wr_q.delete();
        exp_rd_q.delete();
        exp_tx_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_busy", {31'h0, busy}, 32'd0);
        read_frame(16'h0100, 8'd1);
        wait_idle("rd_after_reset", 3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, elapsed %0t, limit 800000", $time);
        $fatal(1, "watchdog");
    end

endmodule
